// File: rtl/pipe_skid_reg.sv
// Two-entry elastic pipeline register (main + skid) with valid/ready on both sides.
// Every output is decoded from flops, so the upstream ready path is combinationally isolated from downstream.
module pipe_skid_reg #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic [1:0]       o_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             in_fire;
    logic             out_fire;

    assign o_valid  = (state != EMPTY);
    assign o_ready  = (state != TWO) & ~i_rst;
    assign o_data   = main_q;
    assign o_count  = {state == TWO, state == ONE};

    assign in_fire  = i_valid & o_ready;
    assign out_fire = o_valid & i_ready;

    // Flush leaves main/skid untouched; only the occupancy is cleared.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= EMPTY;
            main_q <= RESET_VAL;
            skid_q <= RESET_VAL;
        end else if (i_flush) begin
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state  <= ONE;
                        main_q <= i_data;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_q <= i_data;
                    end else if (in_fire) begin
                        state  <= TWO;
                        skid_q <= i_data;
                    end else if (out_fire) begin
                        state <= EMPTY;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        state  <= ONE;
                        main_q <= skid_q;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: directed scenarios with literal expectations,
// then random traffic compared every cycle against a queue-based model.
module tb_pipe_skid_reg;

    localparam int WIDTH = 32;

    logic             i_clk = 1'b0;
    logic             i_rst = 1'b0;
    logic             i_flush = 1'b0;
    logic             i_valid = 1'b0;
    logic             o_ready;
    logic [WIDTH-1:0] i_data = '0;
    logic             o_valid;
    logic             i_ready = 1'b0;
    logic [WIDTH-1:0] o_data;
    logic [1:0]       o_count;

    int checks = 0;
    int failures = 0;

    pipe_skid_reg #(.WIDTH(WIDTH), .RESET_VAL('0)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_flush (i_flush),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  (i_data),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (o_data),
        .o_count (o_count)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a FIFO of at most two payloads.
    logic [WIDTH-1:0] q[$];
    bit               model_known = 0;
    bit               pristine = 0;

    always @(posedge i_clk) begin
        bit in_f, out_f;
        if (i_rst) begin
            q.delete();
            model_known = 1;
            pristine = 1;
        end else begin
            in_f  = i_valid && (q.size() < 2);
            out_f = (q.size() > 0) && i_ready;
            if (out_f) void'(q.pop_front());
            if (i_flush) q.delete();
            else if (in_f) begin
                q.push_back(i_data);
                pristine = 0;
            end
        end
    end

    // Compare process: outputs are checked on the falling edge, away from the active edge.
    always @(negedge i_clk) begin
        if (model_known) begin
            chk("o_valid", 32'(o_valid), 32'(q.size() > 0));
            chk("o_count", 32'(o_count), 32'(q.size()));
            chk("o_ready", 32'(o_ready), 32'((q.size() < 2) && !i_rst));
            if (q.size() > 0) chk("o_data", o_data, q[0]);
            else if (pristine) chk("o_data_reset", o_data, 32'h0);
        end
    end

    task automatic step(input logic rst, input logic flush, input logic valid,
                        input logic [WIDTH-1:0] data, input logic ready);
        i_rst   = rst;
        i_flush = flush;
        i_valid = valid;
        i_data  = data;
        i_ready = ready;
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        #1;
        // Reset with upstream pushing garbage
        step(1, 0, 1, 32'hDEAD, 0);
        step(1, 0, 1, 32'hDEAD, 0);
        chk("rst_valid", 32'(o_valid), 0);
        chk("rst_ready", 32'(o_ready), 0);
        chk("rst_data", o_data, 32'h0);
        step(0, 0, 0, 0, 0);
        chk("post_rst_ready", 32'(o_ready), 1);
        chk("post_rst_count", 32'(o_count), 0);

        // Streaming
        step(0, 0, 1, 32'h1, 1);
        chk("stream_d1", o_data, 32'h1);
        chk("stream_c1", 32'(o_count), 1);
        step(0, 0, 1, 32'h2, 1);
        chk("stream_d2", o_data, 32'h2);
        chk("stream_r2", 32'(o_ready), 1);
        step(0, 0, 1, 32'h3, 1);
        chk("stream_d3", o_data, 32'h3);
        chk("stream_c3", 32'(o_count), 1);
        step(0, 0, 0, 0, 1);
        chk("stream_drain", 32'(o_valid), 0);

        // Backpressure then pop with upstream waiting
        step(0, 0, 1, 32'hA, 0);
        step(0, 0, 1, 32'hB, 0);
        chk("bp_count", 32'(o_count), 2);
        chk("bp_ready", 32'(o_ready), 0);
        chk("bp_data", o_data, 32'hA);
        step(0, 0, 1, 32'hC, 0);
        chk("bp_hold", o_data, 32'hA);
        chk("bp_hold_count", 32'(o_count), 2);
        step(0, 0, 1, 32'hC, 1);
        chk("pop_d_b", o_data, 32'hB);
        chk("pop_ready", 32'(o_ready), 1);
        step(0, 0, 1, 32'hC, 1);
        chk("pop_d_c", o_data, 32'hC);
        chk("pop_count", 32'(o_count), 1);
        step(0, 0, 0, 0, 1);
        chk("pop_empty", 32'(o_valid), 0);

        // Flush while full with same-cycle push
        step(0, 0, 1, 32'hA, 0);
        step(0, 0, 1, 32'hB, 0);
        step(0, 1, 1, 32'hF, 0);
        chk("flush_valid", 32'(o_valid), 0);
        chk("flush_count", 32'(o_count), 0);
        step(0, 0, 0, 0, 1);
        chk("flush_no_f", o_data, 32'hA);
        chk("flush_stays_empty", 32'(o_valid), 0);

        // Reset and flush together from ONE, then normal push
        step(0, 0, 1, 32'h7, 0);
        chk("one_data", o_data, 32'h7);
        step(1, 1, 0, 0, 0);
        chk("rf_valid", 32'(o_valid), 0);
        chk("rf_data", o_data, 32'h0);
        step(0, 0, 1, 32'h5, 0);
        chk("rf_push", o_data, 32'h5);
        chk("rf_push_valid", 32'(o_valid), 1);
        step(0, 0, 0, 0, 1);
        chk("rf_pop", 32'(o_valid), 0);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(63) == 0), ($urandom_range(15) == 0),
                 ($urandom_range(3) != 0), $urandom, ($urandom_range(2) != 0));
        end
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Two-entry elastic pipeline register placed between adjacent pipeline stages, e.g. IF→ID and ID→EX.
- Carries a WIDTH-bit stage payload under a valid/ready handshake on both sides.
- Upstream ready is decoded only from flops, which breaks the combinational ready path between stages.
- Supports a synchronous pipeline flush for branch redirect and exceptions.

Parameters:
- WIDTH, 32, payload width in bits.
- RESET_VAL, 0, value loaded into both data registers on reset.

Ports:
- i_clk  input  1  clock; all state changes on its rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_flush  input  1  synchronous flush; discards all held entries.
- i_valid  input  1  upstream payload valid.
- o_ready  output  1  buffer can accept a payload this cycle.
- i_data  input  WIDTH  upstream payload.
- o_valid  output  1  downstream payload valid.
- i_ready  input  1  downstream accepts this cycle.
- o_data  output  WIDTH  downstream payload; always the oldest held entry.
- o_count  output  2  number of entries held (0..2).

Behaviour:
- Storage: main register (head) and skid register (second entry). State encoding: EMPTY, ONE, TWO.
- Fire definitions:
  - in_fire = i_valid & o_ready
  - out_fire = o_valid & i_ready
- Output decodes, all driven from flops only:
  - o_valid = (state != EMPTY)
  - o_ready = (state != TWO) & !i_rst
  - o_data = main
  - o_count = 0 / 1 / 2 for EMPTY / ONE / TWO
- No combinational path from i_valid, i_ready, i_data or i_flush to any output.
- Transitions when i_rst = 0 and i_flush = 0:
  - EMPTY: in_fire → ONE, main <= i_data. Otherwise hold.
  - ONE:
    - in_fire & out_fire → ONE, main <= i_data
    - in_fire & !out_fire → TWO, skid <= i_data
    - !in_fire & out_fire → EMPTY
    - otherwise hold
  - TWO: out_fire → ONE, main <= skid. Otherwise hold. In TWO, in_fire is impossible because o_ready = 0.
- Latency:
  - Payload accepted in cycle N is presented on o_data with o_valid = 1 in cycle N+1, provided it is at the head.
  - Throughput is one payload per cycle while i_ready is held high.
- Ordering: strict FIFO. No payload is duplicated or dropped except by flush or reset.
- Flush (i_flush = 1):
  - Next state is EMPTY regardless of in_fire/out_fire in that cycle.
  - A same-cycle upstream payload is dropped, even though o_ready may read 1.
  - A same-cycle out_fire still counts as consumed by downstream.
  - main and skid keep their old contents (don't-care).
- Reset (i_rst = 1):
  - Takes priority over flush.
  - Next state EMPTY; main and skid <= RESET_VAL.
  - o_ready forced 0 during the reset cycle(s).
  - Reset asserted mid-transfer discards all entries.
- Post-reset values: o_valid = 0, o_count = 0, o_data = RESET_VAL. o_ready = 1 from the first cycle with i_rst = 0.
- While o_valid = 1 and i_ready = 0, o_data and o_valid must stay stable (downstream hold rule).
- The upstream hold rule is the caller's responsibility. The block does not check it.

Test Plan:
- Reset: assert i_rst 2 cycles with i_valid = 1, i_data = 0xDEAD → o_valid = 0, o_ready = 0, o_data = 0 (RESET_VAL); after release o_ready = 1, o_count = 0.
- Streaming: i_ready = 1, push 0x1, 0x2, 0x3 on consecutive cycles → o_data shows 0x1, 0x2, 0x3 on the following consecutive cycles; o_count stays 1; o_ready stays 1.
- Backpressure: i_ready = 0, push 0xA then 0xB → o_count = 2, o_ready = 0, o_data = 0xA held stable. Then raise i_ready → 0xA, then 0xB delivered; o_ready = 1 again the cycle after the first pop.
- Full-state pop with upstream waiting: state TWO holding 0xA/0xB, i_valid = 1 with 0xC, i_ready = 1 → delivery order 0xA, 0xB, 0xC, with no loss and no duplicate.
- Flush: state TWO, assert i_flush with i_valid = 1 and i_data = 0xF → next cycle o_valid = 0, o_count = 0; 0xF never appears on o_data.
- Reset vs flush and mid-operation: state ONE, assert i_rst and i_flush together → EMPTY, o_data = RESET_VAL. A subsequent push of 0x5 is delivered normally.
